// File: rtl/counter_check_pkg.sv
// Shared types and constants for the counter stream checker.
package counter_check_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_VERIFY  = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  // Count up to all-ones and hold there until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + ONE;
  end

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side checker for an incrementing counter bus: acquires lock on the
// +1 sequence and flags/counts every break once locked.
// Optional capture of the first locked mismatch: define COUNTER_CHECK_CAPTURE_EN.
module counter_stream_checker
  import counter_check_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 enable_i,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 clear_i,
`ifdef COUNTER_CHECK_CAPTURE_EN
  output logic                 cap_valid_o,
  output logic [WIDTH-1:0]     cap_exp_o,
  output logic [WIDTH-1:0]     cap_act_o,
`endif
  output logic                 locked_o,
  output logic                 error_o,
  output logic [ERR_WIDTH-1:0] err_count_o,
  output logic [1:0]           state_o
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] ONE_D    = WIDTH'(1);
  localparam logic [RW-1:0]    ONE_R    = RW'(1);
  localparam logic [MW-1:0]    ONE_M    = MW'(1);
  localparam logic [RW-1:0]    RUN_LAST = RW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0]    MISS_LAST = MW'(UNLOCK_COUNT - 1);

  state_t            state, state_n;
  logic [WIDTH-1:0]  expected, exp_n;
  logic [RW-1:0]     run, run_n;
  logic [MW-1:0]     miss, miss_n;
  logic              hit;

  wire match = (data_i == expected);

  // Next-state and datapath decisions; a locked mismatch raises hit.
  always_comb begin
    state_n = state;
    exp_n   = expected;
    run_n   = run;
    miss_n  = miss;
    hit     = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      run_n   = '0;
      miss_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = ACQUIRE;
        ACQUIRE: if (valid_i) begin
          exp_n   = data_i + ONE_D;
          run_n   = '0;
          state_n = VERIFY;
        end
        VERIFY: if (valid_i) begin
          if (match) begin
            exp_n = expected + ONE_D;
            run_n = run + ONE_R;
            if (run == RUN_LAST) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            // Reseed silently while still acquiring.
            exp_n = data_i + ONE_D;
            run_n = '0;
          end
        end
        LOCKED: if (valid_i) begin
          if (match) begin
            exp_n  = expected + ONE_D;
            miss_n = '0;
          end else begin
            hit    = 1'b1;
            exp_n  = data_i + ONE_D;
            miss_n = miss + ONE_M;
            if (miss == MISS_LAST) begin
              state_n = VERIFY;
              run_n   = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, expected/run/miss and the registered error pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      expected <= '0;
      run      <= '0;
      miss     <= '0;
      error_o  <= 1'b0;
    end else begin
      state    <= state_n;
      expected <= exp_n;
      run      <= run_n;
      miss     <= miss_n;
      error_o  <= hit;
    end
  end

  sat_counter #(.W(ERR_WIDTH)) u_err_cnt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (clear_i),
    .inc   (hit),
    .cnt   (err_count_o)
  );

  assign locked_o = (state == LOCKED);
  assign state_o  = state;

`ifdef COUNTER_CHECK_CAPTURE_EN
  // Hold the first locked mismatch until reset or clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_valid_o <= 1'b0;
      cap_exp_o   <= '0;
      cap_act_o   <= '0;
    end else if (clear_i) begin
      cap_valid_o <= 1'b0;
      cap_exp_o   <= '0;
      cap_act_o   <= '0;
    end else if (hit && !cap_valid_o) begin
      cap_valid_o <= 1'b1;
      cap_exp_o   <= expected;
      cap_act_o   <= data_i;
    end
  end
`endif

endmodule

// File: tb/tb_counter_stream_checker.sv
// Directed bench for counter_stream_checker (default build).
module tb_counter_stream_checker;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        enable_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        clear_i = 1'b0;
  logic        locked_o;
  logic        error_o;
  logic [15:0] err_count_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  counter_stream_checker dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .enable_i    (enable_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .clear_i     (clear_i),
    .locked_o    (locked_o),
    .error_o     (error_o),
    .err_count_o (err_count_o),
    .state_o     (state_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, settle 1 time unit past it.
  task automatic step(input logic v, input logic [15:0] d);
    valid_i = v;
    data_i  = d;
    @(posedge CLK);
    #1;
  endtask

  // Expect full status after a step.
  task automatic expect_st(input string tag, input logic [1:0] st, input logic err,
                           input logic [15:0] cnt);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".locked"}, 32'(locked_o), 32'(st == 2'd3));
    chk({tag, ".error"}, 32'(error_o), 32'(err));
    chk({tag, ".count"}, 32'(err_count_o), 32'(cnt));
  endtask

  initial begin
    // Reset state
    #2;
    expect_st("reset", 2'd0, 1'b0, 16'd0);
    #10;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    expect_st("idle_hold", 2'd0, 1'b0, 16'd0);

    // Clean stream 0x0000..0x0010
    enable_i = 1'b1;
    step(1'b0, 16'h0);
    expect_st("to_acquire", 2'd1, 1'b0, 16'd0);
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, 16'(i));
      expect_st($sformatf("clean%0d", i), (i >= 4) ? 2'd3 : ((i == 0) ? 2'd2 : 2'd2), 1'b0, 16'd0);
    end
    // valid low with garbage data changes nothing
    step(1'b0, 16'hBEEF);
    expect_st("valid_low", 2'd3, 1'b0, 16'd0);
    step(1'b1, 16'h0011);
    expect_st("after_gap", 2'd3, 1'b0, 16'd0);

    // Wrap: relock on FFFB seed, FFFC..FFFF, then 0000, 0001
    enable_i = 1'b0;
    step(1'b1, 16'h1234);
    expect_st("disable", 2'd0, 1'b0, 16'd0);
    enable_i = 1'b1;
    step(1'b0, 16'h0);
    step(1'b1, 16'hFFFB);
    step(1'b1, 16'hFFFC);
    step(1'b1, 16'hFFFD);
    step(1'b1, 16'hFFFE);
    expect_st("wrap_pre", 2'd2, 1'b0, 16'd0);
    step(1'b1, 16'hFFFF);
    expect_st("wrap_lock", 2'd3, 1'b0, 16'd0);
    step(1'b1, 16'h0000);
    expect_st("wrap_0", 2'd3, 1'b0, 16'd0);
    step(1'b1, 16'h0001);
    expect_st("wrap_1", 2'd3, 1'b0, 16'd0);

    // Single glitch with expected 0x0100
    enable_i = 1'b0;
    step(1'b0, 16'h0);
    enable_i = 1'b1;
    step(1'b0, 16'h0);
    for (int i = 16'h00FB; i <= 16'h00FF; i++) step(1'b1, 16'(i));
    expect_st("glitch_lock", 2'd3, 1'b0, 16'd0);
    step(1'b1, 16'h0105);
    expect_st("glitch_hit", 2'd3, 1'b1, 16'd1);
    step(1'b1, 16'h0106);
    expect_st("glitch_resync", 2'd3, 1'b0, 16'd1);

    // Clear on a matching sample, then loss of lock
    clear_i = 1'b1;
    step(1'b1, 16'h0107);
    clear_i = 1'b0;
    expect_st("clear_match", 2'd3, 1'b0, 16'd0);
    step(1'b1, 16'h0200);
    expect_st("lol_1", 2'd3, 1'b1, 16'd1);
    step(1'b1, 16'h0300);
    expect_st("lol_2", 2'd2, 1'b1, 16'd2);
    step(1'b1, 16'h0301);
    step(1'b1, 16'h0302);
    step(1'b1, 16'h0303);
    expect_st("relock_pre", 2'd2, 1'b0, 16'd2);
    step(1'b1, 16'h0304);
    expect_st("relock", 2'd3, 1'b0, 16'd2);

    // Build err_count to 5 with isolated mismatches
    step(1'b1, 16'h0400);
    step(1'b1, 16'h0401);
    step(1'b1, 16'h0500);
    step(1'b1, 16'h0501);
    step(1'b1, 16'h0600);
    expect_st("cnt5_hit", 2'd3, 1'b1, 16'd5);
    step(1'b1, 16'h0601);
    expect_st("cnt5", 2'd3, 1'b0, 16'd5);

    // Clear collides with a locked mismatch
    clear_i = 1'b1;
    step(1'b1, 16'h0700);
    clear_i = 1'b0;
    expect_st("clr_collide", 2'd3, 1'b1, 16'd0);
    step(1'b1, 16'h0800);
    expect_st("post_clr", 2'd2, 1'b1, 16'd1);

    // Async reset between edges
    #3;
    RESET_N = 1'b0;
    #1;
    expect_st("async_rst", 2'd0, 1'b0, 16'd0);
    #10;
    RESET_N = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_stream_checker.md
# counter_stream_checker

Receive-side checker for the free-running fabric counter pattern. Samples a WIDTH-bit value driven off-fabric by an incrementing counter, acquires lock on the +1 sequence, and flags and counts every break in that sequence. It sits on the tile I/O pins that carry the counter bus and gives a pass/fail signal for bring-up of routed sequential designs.

## Interface
- WIDTH, 16: sampled bus width; the sequence wraps modulo 2^WIDTH.
- LOCK_COUNT, 4: consecutive matching samples (after the seed) needed to declare lock; must be at least 1.
- UNLOCK_COUNT, 2: consecutive mismatches while locked before lock is dropped; must be at least 1.
- ERR_WIDTH, 16: width of the error counter.

- CLK  in  1  the single clock, from the global clock primitive.
- RESET_N  in  1  asynchronous, active-low reset.
- enable_i  in  1  checker enable; low forces IDLE.
- valid_i  in  1  data_i holds a new sample this cycle.
- data_i  in  WIDTH  sampled counter value.
- clear_i  in  1  synchronous clear of the error counter and the capture registers.
- locked_o  out  1  high in LOCKED.
- error_o  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count_o  out  ERR_WIDTH  saturating count of mismatches.
- state_o  out  2  current state encoding.

## Operation
- States: IDLE=0, ACQUIRE=1, VERIFY=2, LOCKED=3. Registers: expected (WIDTH), run (match count), miss (mismatch count).
- IDLE: enable_i=1 moves to ACQUIRE. enable_i=0 in any state moves to IDLE on the next edge and clears run and miss. err_count is held.
- ACQUIRE: on valid_i, expected<=data_i+1 and run<=0, then move to VERIFY.
- VERIFY:
  - valid_i with data_i==expected: expected<=expected+1 and run<=run+1. If run+1==LOCK_COUNT, move to LOCKED and set miss<=0.
  - Mismatch: expected<=data_i+1 and run<=0. Stay in VERIFY. No error is raised.
- LOCKED:
  - Match: expected<=expected+1 and miss<=0.
  - Mismatch: pulse error_o, increment err_count (saturating at all-ones), resync expected<=data_i+1, miss<=miss+1. If miss+1==UNLOCK_COUNT, move to VERIFY with run<=0.
- Cycles with valid_i low change nothing.
- Arithmetic is modulo 2^WIDTH. With expected=16'hFFFF, the next expected value is 16'h0000, and a sample of 0000 is a match.
- clear_i has priority over an increment in the same cycle: err_count becomes 0, but error_o still pulses. clear_i does not change the state.

## Timing
- All outputs are registered.
- Reset values: state IDLE, locked_o=0, error_o=0, err_count_o=0, state_o=0, and expected/run/miss all 0.
- error_o goes high on the cycle after the edge that sampled the offending data_i, for exactly one cycle. err_count_o updates on the same cycle as error_o.
- locked_o rises on the cycle after the LOCK_COUNT-th matching sample. With defaults this is 1 seed + 4 matches = 5 valid samples.
- Reset asserted mid-operation returns all state and outputs to their reset values immediately, with no dependence on CLK.
- Back-to-back valid_i on every cycle is supported; throughput is one sample per cycle.

## Configuration
- COUNTER_CHECK_CAPTURE_EN defined:
  - Adds outputs cap_valid_o (1), cap_exp_o (WIDTH) and cap_act_o (WIDTH).
  - The first LOCKED mismatch after reset or clear_i loads the expected and actual values and sets cap_valid_o. Later mismatches do not overwrite them.
  - clear_i zeroes all three outputs.
- Undefined: the three ports and their registers do not exist. All other behaviour is identical.

## Structure
- Package counter_check_pkg holds:
  - the state typedef (2-bit enum: IDLE, ACQUIRE, VERIFY, LOCKED);
  - the state encoding constants;
  - the default WIDTH.
- One sub-module: sat_counter, a saturating up-counter with synchronous clear and increment, parameterised by width. It is used for err_count.
- The FSM and the expected/run/miss datapath live in the top module.

## Test plan
- Clean stream: enable_i=1, feed 0x0000..0x0010 with valid every cycle → locked_o rises the cycle after sample 0x0004; err_count_o=0 and error_o never pulses.
- Wrap: lock on 0xFFFC..0xFFFF, then feed 0x0000, 0x0001 → no error and locked_o stays 1.
- Single glitch: locked at expected 0x0100, feed 0x0105 then 0x0106 → one error_o pulse, err_count_o=1, still LOCKED (resync).
- Loss of lock: locked, feed 0x0200 then 0x0300 → two pulses, err_count_o=2, state_o=2. Then 0x0301..0x0304 → relock with locked_o=1.
- Clear/error collision: assert clear_i on the same cycle a locked mismatch is sampled, with err_count_o=5 → error_o pulses and err_count_o=0. With COUNTER_CHECK_CAPTURE_EN defined, cap_valid_o=0.
- Async reset: drop RESET_N mid-stream between clock edges → state_o=0, locked_o=0 and err_count_o=0 before the next CLK edge.
